// File: rtl/skinny_mask_pkg.sv
// Shared constants and FSM state type for the masked Skinny-64 S-box layer control.
package skinny_mask_pkg;
  localparam int SKINNY_SHARES  = 3;
  localparam int SBOX_LATENCY   = 9;
  localparam int SBOX_FRESH_W   = 63;
  localparam int SKINNY_NIBBLES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;
endpackage

// File: rtl/sbox_tag_pipe.sv
// LATENCY-deep {valid, index} tag line that travels alongside the S-box pipeline; never stalls.
module sbox_tag_pipe #(
  parameter int LATENCY = 9,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);
  logic [LATENCY:0]            vld_pipe;
  logic [LATENCY:0][IDX_W-1:0] idx_pipe;
  logic [LATENCY:1]            vld_q;
  logic [LATENCY:1][IDX_W-1:0] idx_q;

  assign vld_pipe = {vld_q, in_valid};
  assign idx_pipe = {idx_q, in_idx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_pipe[LATENCY-1:0];
      idx_q <= idx_pipe[LATENCY-1:0];
    end
  end

  assign out_valid = vld_pipe[LATENCY];
  assign out_idx   = idx_pipe[LATENCY];
endmodule

// File: rtl/skinny_sbox_layer_ctrl.sv
// Streams the 16 shared nibbles of a Skinny-64 state through the external 3-share pipelined
// S-box, feeds it fresh randomness, and reassembles the shared result from the tagged returns.
module skinny_sbox_layer_ctrl
  import skinny_mask_pkg::*;
#(
  parameter int SHARES  = SKINNY_SHARES,
  parameter int LATENCY = SBOX_LATENCY,
  parameter int NIBBLES = SKINNY_NIBBLES,
  parameter int FRESH_W = SBOX_FRESH_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SHARES*4*NIBBLES-1:0] state_in,
  output logic                      busy,
  output logic                      done,
  output logic                      rand_err,
  output logic [SHARES*4*NIBBLES-1:0] state_out,
  input  logic                      prng_valid,
  input  logic [FRESH_W-1:0]        prng_data,
  output logic                      prng_ready,
  output logic [SHARES*4-1:0]       sbox_x,
  output logic [FRESH_W-1:0]        sbox_fresh,
  input  logic [SHARES*4-1:0]       sbox_y
);
  localparam int IDX_W = $clog2(NIBBLES);
  localparam int W     = 4 * NIBBLES;

  ctrl_state_t                 st;
  logic [SHARES-1:0][W-1:0]    load_q;
  logic [SHARES-1:0][W-1:0]    out_q;
  logic [IDX_W-1:0]            issue_cnt;
  logic [IDX_W:0]              ret_cnt;
  logic [IDX_W:0]              ret_cnt_nxt;
  logic                        issuing;
  logic                        active;
  logic                        tag_vld;
  logic [IDX_W-1:0]            tag_idx;

  assign issuing     = (st == ISSUE);
  assign active      = (st == ISSUE) || (st == DRAIN);
  assign ret_cnt_nxt = ret_cnt + {{IDX_W{1'b0}}, tag_vld};

  // A fresh word is only forwarded when it is both needed and valid, so no word is ever reused.
  assign prng_ready = active;
  assign sbox_fresh = (active && prng_valid) ? prng_data : '0;

  // Each share is muxed independently; shares never meet inside this block.
  for (genvar k = 0; k < SHARES; k++) begin : g_share
    assign sbox_x[4*k +: 4] = issuing ? load_q[k][4*issue_cnt +: 4] : 4'h0;
  end

  sbox_tag_pipe #(
    .LATENCY (LATENCY),
    .IDX_W   (IDX_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issuing),
    .in_idx    (issue_cnt),
    .out_valid (tag_vld),
    .out_idx   (tag_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      load_q    <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rand_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (active && !prng_valid) rand_err <= 1'b1;
      if (tag_vld) ret_cnt <= ret_cnt_nxt;
      case (st)
        IDLE: begin
          if (start) begin
            load_q    <= state_in;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            rand_err  <= 1'b0;
            busy      <= 1'b1;
            st        <= ISSUE;
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + 1'b1;
          if (issue_cnt == IDX_W'(NIBBLES - 1)) st <= DRAIN;
        end
        DRAIN: begin
          // Done is raised on the edge that captures the last nibble.
          if (ret_cnt_nxt == (IDX_W+1)'(NIBBLES)) begin
            busy <= 1'b0;
            done <= 1'b1;
            st   <= DONE;
          end
        end
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (tag_vld) begin
      for (int k = 0; k < SHARES; k++) out_q[k][4*tag_idx +: 4] <= sbox_y[4*k +: 4];
    end
  end

  assign state_out = out_q;
endmodule

// File: tb/tb_skinny_sbox_layer_ctrl.sv
// Directed bench with a behavioural 9-stage remasking S-box and an expected-result queue.
module tb_skinny_sbox_layer_ctrl;
  localparam int LAT = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [191:0] state_in;
  logic         busy, done, rand_err;
  logic [191:0] state_out;
  logic         prng_valid;
  logic [62:0]  prng_data;
  logic         prng_ready;
  logic [11:0]  sbox_x;
  logic [62:0]  sbox_fresh;
  logic [11:0]  sbox_y;

  int checks = 0;
  int errors = 0;
  int gcyc   = 0;

  typedef struct { logic [63:0] res; logic err; } exp_t;
  exp_t sb[$];

  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                                       4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

  skinny_sbox_layer_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .state_in   (state_in),
    .busy       (busy),
    .done       (done),
    .rand_err   (rand_err),
    .state_out  (state_out),
    .prng_valid (prng_valid),
    .prng_data  (prng_data),
    .prng_ready (prng_ready),
    .sbox_x     (sbox_x),
    .sbox_fresh (sbox_fresh),
    .sbox_y     (sbox_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) gcyc++;

  function automatic logic [63:0] layer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = SBOX[x[4*i +: 4]];
    return r;
  endfunction

  function automatic logic [63:0] recomb(input logic [191:0] s);
    return s[63:0] ^ s[127:64] ^ s[191:128];
  endfunction

  // Behavioural masked S-box: recombine, substitute, re-split with new masks, delay LAT stages.
  logic [11:0] pipe [1:LAT];
  initial for (int k = 1; k <= LAT; k++) pipe[k] = '0;
  always @(posedge clk) begin : sbox_model
    logic [3:0] x, m1, m2;
    x  = sbox_x[3:0] ^ sbox_x[7:4] ^ sbox_x[11:8];
    m1 = 4'($urandom);
    m2 = 4'($urandom);
    for (int k = LAT; k >= 2; k--) pipe[k] <= pipe[k-1];
    pipe[1] <= {m2, m1, SBOX[x] ^ m1 ^ m2};
  end
  assign sbox_y = pipe[LAT];

  always @(negedge clk) prng_data = 63'({$urandom, $urandom});

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Randomness handshake rules, checked every cycle away from the clock edge.
  always @(posedge clk) begin
    #1;
    chk("ready_outside_busy", 192'(prng_ready & ~busy), 192'd0);
    chk("fresh_bus", 192'(sbox_fresh), (prng_ready && prng_valid) ? 192'(prng_data) : 192'd0);
  end

  task automatic do_start(input logic [191:0] st, input logic err);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    state_in = st;
    @(negedge clk);
    start    = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    e.res = layer(recomb(st));
    e.err = err;
    sb.push_back(e);
  endtask

  // Returns in the middle of the done cycle; cycle 1 is the one following the start edge.
  task automatic wait_done(input int drop, input int s_a, input int s_b, input int zchk,
                           output int dcyc);
    int   cyc = 1;
    logic busy_ok = 1'b1;
    exp_t e;
    dcyc = 0;
    while (cyc < 40) begin
      start      = (cyc == s_a) || (cyc == s_b);
      prng_valid = (cyc != drop);
      if (cyc == zchk) chk("no_stale_capture", state_out, 192'd0);
      if (done) begin
        dcyc = cyc;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start      = 1'b0;
    prng_valid = 1'b1;
    chk("done_latency", 192'(dcyc), 192'd26);
    chk("busy_until_done", 192'(busy_ok), 192'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 192'd0, 192'd1);
    end else begin
      e = sb.pop_front();
      chk("layer_result", 192'(recomb(state_out)), 192'(e.res));
      chk("rand_err", 192'(rand_err), 192'(e.err));
    end
  endtask

  function automatic logic [191:0] split(input logic [63:0] x);
    logic [63:0] s1, s2;
    s1 = {$urandom, $urandom};
    s2 = {$urandom, $urandom};
    return {s2, s1, x ^ s1 ^ s2};
  endfunction

  initial begin
    int d, t0, t1, t2, extra;
    rst_n      = 1'b0;
    start      = 1'b0;
    state_in   = '0;
    prng_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 192'(busy), 192'd0);
    chk("rst_done", 192'(done), 192'd0);
    chk("rst_rand_err", 192'(rand_err), 192'd0);
    chk("rst_state_out", state_out, 192'd0);
    chk("rst_prng_ready", 192'(prng_ready), 192'd0);
    chk("rst_sbox_x", 192'(sbox_x), 192'd0);
    chk("rst_sbox_fresh", 192'(sbox_fresh), 192'd0);
    rst_n = 1'b1;

    // Known vector, only share 0 populated.
    do_start({64'd0, 64'd0, 64'h0123456789ABCDEF}, 1'b0);
    wait_done(0, 0, 0, 0, d);

    for (int it = 0; it < 100; it++) begin
      do_start(split({$urandom, $urandom}), 1'b0);
      wait_done(0, 0, 0, 0, d);
    end

    // PRNG starves for one cycle while draining.
    do_start(split(64'hFEDCBA9876543210), 1'b1);
    wait_done(20, 0, 0, 0, d);
    do_start(split(64'h0F1E2D3C4B5A6978), 1'b0);
    wait_done(0, 0, 0, 0, d);

    // Starts while busy are ignored; only one done follows.
    do_start(split(64'h5555AAAA3333CCCC), 1'b0);
    wait_done(0, 3, 10, 0, d);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("single_done", 192'(extra), 192'd0);

    // Reset mid-operation: outputs clear, in-flight results dropped.
    do_start(split(64'h1122334455667788), 1'b0);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {busy, done, rand_err, prng_ready, sbox_x, sbox_fresh}, 192'd0);
    chk("midrst_state_out", state_out, 192'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_start(split(64'h99AABBCCDDEEFF00), 1'b0);
    wait_done(0, 0, 0, 10, d);

    // Back-to-back operations, each start in the cycle after the previous done.
    do_start(split(64'hCAFEBABEDEADBEEF), 1'b0);
    wait_done(0, 0, 0, 0, d);
    t0 = gcyc;
    do_start(split(64'h0011223344556677), 1'b0);
    wait_done(0, 0, 0, 0, d);
    t1 = gcyc;
    do_start(split(64'h8899AABBCCDDEEFF), 1'b0);
    wait_done(0, 0, 0, 0, d);
    t2 = gcyc;
    chk("b2b_gap_1", 192'(t1 - t0), 192'd27);
    chk("b2b_gap_2", 192'(t2 - t1), 192'd27);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
